// File: rtl/rx_intf_m_axis_pkg.sv
// Shared types and constants for the receive-direction AXI4-Stream master.
package rx_intf_m_axis_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FLUSH
  } state_t;

  // Wide enough for any practical TDATA width; the top slices what it needs.
  localparam logic [127:0] TSTRB_ALL = '1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rx_intf_fifo64_fwft.sv
// Single-clock first-word-fall-through FIFO; RST is the block's asynchronous
// active-low reset. DATAO shows the head word whenever EMPTY is low.
module rx_intf_fifo64_fwft #(
  parameter int DEPTH  = 8192,
  parameter int CNT_W  = 14,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DI,
  input  logic              WREN,
  input  logic              RDEN,
  output logic [DATA_W-1:0] DATAO,
  output logic              EMPTY,
  output logic              FULL,
  output logic [CNT_W-1:0]  data_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr;
  logic              rd;

  // FULL/EMPTY come from the registered count, so a write on a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign wr         = WREN & ~FULL;
  assign rd         = RDEN & ~EMPTY;
  assign FULL       = (count == CNT_W'(DEPTH));
  assign EMPTY      = (count == '0);
  assign data_count = count;
  assign DATAO      = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= DI;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_intf_m_axis.sv
// AXI4-Stream master sending buffered receive words to DMA as fixed-length
// bursts. Define RX_INTF_M_AXIS_TIMEOUT_EN to enable the stall-timeout flush.
module rx_intf_m_axis
  import rx_intf_m_axis_pkg::*;
#(
  parameter int MAX_NUM_DMA_SYMBOL     = 8192,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int C_M_AXIS_TDATA_WIDTH   = 64,
  parameter int TIMEOUT_CYCLES         = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DATA_FROM_ACC,
  input  logic                                DATA_FROM_ACC_VALID,
  output logic                                fifo_full,
  output logic                                overflow,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   data_count,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   M_AXIS_NUM_DMA_SYMBOL,
  input  logic                                start_1trans,
  output logic                                m_axis_busy,
  output logic                                timeout_flag,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST
);

  localparam int CW     = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;

  state_t                          state;
  state_t                          state_nxt;
  logic [CW-1:0]                   len;
  logic [CW-1:0]                   beat;
  logic                            fifo_empty;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_head;
  logic                            tvalid;
  logic                            hs;
  logic                            last;
  logic                            pop;

  rx_intf_fifo64_fwft #(
    .DEPTH  (MAX_NUM_DMA_SYMBOL),
    .CNT_W  (CW),
    .DATA_W (C_M_AXIS_TDATA_WIDTH)
  ) u_fifo (
    .CLK        (M_AXIS_ACLK),
    .RST        (M_AXIS_ARESETN),
    .DI         (DATA_FROM_ACC),
    .WREN       (DATA_FROM_ACC_VALID),
    .RDEN       (pop),
    .DATAO      (fifo_head),
    .EMPTY      (fifo_empty),
    .FULL       (fifo_full),
    .data_count (data_count)
  );

  assign hs   = tvalid & M_AXIS_TREADY;
  assign last = tvalid & (beat == len);
  assign pop  = hs & (state == SEND);

  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TLAST  = last;
  assign M_AXIS_TSTRB  = tvalid ? TSTRB_ALL[STRB_W-1:0] : '0;
  assign M_AXIS_TDATA  = (state == SEND && !fifo_empty) ? fifo_head : '0;
  assign m_axis_busy   = (state != IDLE);

`ifdef RX_INTF_M_AXIS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            to_flag;

  assign to_hit       = (state == SEND) && fifo_empty && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = to_flag;

  // Counts consecutive empty cycles while a burst is waiting for data.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == SEND && fifo_empty) to_cnt <= to_cnt + 1'b1;
      else                             to_cnt <= '0;
      if (state == IDLE && start_1trans) to_flag <= 1'b0;
      else if (to_hit)                   to_flag <= 1'b1;
    end
  end
`else
  logic to_hit;
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign timeout_flag       = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state    <= IDLE;
      len      <= '0;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (DATA_FROM_ACC_VALID && fifo_full) overflow <= 1'b1;
      if (state == IDLE && start_1trans) begin
        len  <= M_AXIS_NUM_DMA_SYMBOL;
        beat <= '0;
      end else if (hs) begin
        // Wrap on the last beat so the counter never exceeds len.
        beat <= last ? '0 : beat + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tvalid    = 1'b0;
    case (state)
      IDLE: begin
        if (start_1trans) state_nxt = SEND;
      end
      SEND: begin
        tvalid = !fifo_empty;
        if (hs && last)  state_nxt = IDLE;
        else if (to_hit) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Pads the burst with zero beats so the DMA transfer still completes.
        tvalid = 1'b1;
        if (hs && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_intf_m_axis.sv
// Directed, scoreboard-based bench for rx_intf_m_axis; the timeout scenario
// follows whichever build RX_INTF_M_AXIS_TIMEOUT_EN selects.
module tb_rx_intf_m_axis;

  localparam int DEPTH = 8192;
  localparam int CW    = 14;
  localparam int DW    = 64;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] acc_data = '0;
  logic          acc_valid = 1'b0;
  logic          fifo_full;
  logic          overflow;
  logic [CW-1:0] data_count;
  logic [CW-1:0] num_sym = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          timeout_flag;
  logic          tvalid;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tlast;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_len = 0;
  int            exp_beat = 0;
  int            beat_cnt = 0;
  logic          stalled = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic          held_last = 1'b0;

  rx_intf_m_axis #(
    .MAX_NUM_DMA_SYMBOL     (DEPTH),
    .MAX_BIT_NUM_DMA_SYMBOL (CW),
    .C_M_AXIS_TDATA_WIDTH   (DW),
    .TIMEOUT_CYCLES         (TO)
  ) dut (
    .M_AXIS_ACLK           (clk),
    .M_AXIS_ARESETN        (rst_n),
    .DATA_FROM_ACC         (acc_data),
    .DATA_FROM_ACC_VALID   (acc_valid),
    .fifo_full             (fifo_full),
    .overflow              (overflow),
    .data_count            (data_count),
    .M_AXIS_NUM_DMA_SYMBOL (num_sym),
    .start_1trans          (start),
    .m_axis_busy           (busy),
    .timeout_flag          (timeout_flag),
    .M_AXIS_TVALID         (tvalid),
    .M_AXIS_TREADY         (tready),
    .M_AXIS_TDATA          (tdata),
    .M_AXIS_TSTRB          (tstrb),
    .M_AXIS_TLAST          (tlast)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [DW-1:0] d);
    acc_data  = d;
    acc_valid = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    step();
    acc_valid = 1'b0;
  endtask

  task automatic startBurst(input int len);
    num_sym  = CW'(len);
    start    = 1'b1;
    exp_len  = len;
    exp_beat = 0;
    step();
    start = 1'b0;
  endtask

  task automatic waitBeats(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && beat_cnt < n; k++) step();
    checkEq(tag, 64'(beat_cnt), 64'(n));
  endtask

  // Monitor: samples at the falling edge what the next rising edge will accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      logic [DW-1:0] expd;
      logic          expl;
      if (stalled) begin
        checkEq("hold_valid", 64'(tvalid), 64'd1);
        checkEq("hold_data", tdata, held_data);
        checkEq("hold_last", 64'(tlast), 64'(held_last));
      end
      if (tvalid && tready) begin
        expd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        expl = (exp_beat == exp_len);
        checkEq("beat_data", tdata, expd);
        checkEq("beat_last", 64'(tlast), 64'(expl));
        checkEq("beat_strb", 64'(tstrb), 64'hFF);
        exp_beat = expl ? 0 : exp_beat + 1;
        beat_cnt++;
        stalled = 1'b0;
      end else if (tvalid) begin
        stalled   = 1'b1;
        held_data = tdata;
        held_last = tlast;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checkEq("rst_tvalid", 64'(tvalid), 64'd0);
    checkEq("rst_tlast", 64'(tlast), 64'd0);
    checkEq("rst_busy", 64'(busy), 64'd0);
    checkEq("rst_overflow", 64'(overflow), 64'd0);
    checkEq("rst_timeout", 64'(timeout_flag), 64'd0);
    checkEq("rst_tdata", tdata, 64'd0);
    checkEq("rst_count", 64'(data_count), 64'd0);
    checkEq("rst_full", 64'(fifo_full), 64'd0);

    // Four-beat burst at full throughput.
    for (int i = 1; i <= 4; i++) writeWord(64'(i * 'h11));
    checkEq("t1_count", 64'(data_count), 64'd4);
    tready   = 1'b1;
    beat_cnt = 0;
    startBurst(3);
    checkEq("t1_busy_rise", 64'(busy), 64'd1);
    checkEq("t1_first_valid", 64'(tvalid), 64'd1);
    checkEq("t1_first_data", tdata, 64'h11);
    repeat (4) step();
    checkEq("t1_beats", 64'(beat_cnt), 64'd4);
    checkEq("t1_busy_fall", 64'(busy), 64'd0);
    checkEq("t1_count_end", 64'(data_count), 64'd0);
    checkEq("t1_idle_valid", 64'(tvalid), 64'd0);

    // Eight-beat burst with TREADY toggling every cycle.
    tready = 1'b0;
    for (int i = 0; i < 8; i++) writeWord(64'h100 + 64'(i));
    beat_cnt = 0;
    startBurst(7);
    for (int k = 0; k < 100 && beat_cnt < 8; k++) begin
      tready = ~tready;
      step();
    end
    tready = 1'b0;
    repeat (3) step();
    checkEq("t2_beats", 64'(beat_cnt), 64'd8);
    checkEq("t2_busy", 64'(busy), 64'd0);
    checkEq("t2_count", 64'(data_count), 64'd0);

    // Second start and length change during a burst are ignored.
    for (int i = 0; i < 6; i++) writeWord(64'h200 + 64'(i));
    beat_cnt = 0;
    startBurst(3);
    num_sym = CW'(9);
    start   = 1'b1;
    step();
    start  = 1'b0;
    tready = 1'b1;
    waitBeats("t3_wait", 4, 50);
    repeat (3) step();
    checkEq("t3_beats", 64'(beat_cnt), 64'd4);
    checkEq("t3_busy", 64'(busy), 64'd0);
    checkEq("t3_leftover", 64'(data_count), 64'd2);
    startBurst(1);
    waitBeats("t3_carry_wait", 6, 50);
    step();
    checkEq("t3_carry_count", 64'(data_count), 64'd0);
    checkEq("t3_carry_busy", 64'(busy), 64'd0);

    // Fill to capacity plus one dropped write, then drain everything.
    tready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) writeWord(64'hA000_0000 + 64'(i));
    checkEq("t4_full", 64'(fifo_full), 64'd1);
    checkEq("t4_overflow", 64'(overflow), 64'd1);
    checkEq("t4_count", 64'(data_count), 64'(DEPTH));
    tready   = 1'b1;
    beat_cnt = 0;
    startBurst(DEPTH - 1);
    waitBeats("t4_drain_wait", DEPTH, DEPTH + 100);
    repeat (3) step();
    checkEq("t4_beats", 64'(beat_cnt), 64'(DEPTH));
    checkEq("t4_busy", 64'(busy), 64'd0);
    checkEq("t4_count_end", 64'(data_count), 64'd0);
    checkEq("t4_no_extra", 64'(tvalid), 64'd0);
    checkEq("t4_full_end", 64'(fifo_full), 64'd0);

    // Reset after two beats of a four-beat burst.
    tready = 1'b0;
    for (int i = 0; i < 4; i++) writeWord(64'h300 + 64'(i));
    beat_cnt = 0;
    startBurst(3);
    tready = 1'b1;
    step();
    step();
    checkEq("t5_two_beats", 64'(beat_cnt), 64'd2);
    tready = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    exp_beat = 0;
    #1;
    checkEq("t5_rst_valid", 64'(tvalid), 64'd0);
    checkEq("t5_rst_count", 64'(data_count), 64'd0);
    checkEq("t5_rst_busy", 64'(busy), 64'd0);
    checkEq("t5_rst_overflow", 64'(overflow), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    writeWord(64'h5A5A);
    tready   = 1'b1;
    beat_cnt = 0;
    startBurst(0);
    step();
    step();
    checkEq("t5_single_beats", 64'(beat_cnt), 64'd1);
    checkEq("t5_single_busy", 64'(busy), 64'd0);

    // Burst that starves after one word.
    beat_cnt = 0;
    writeWord(64'h77);
    startBurst(3);
`ifdef RX_INTF_M_AXIS_TIMEOUT_EN
    waitBeats("t6_flush_wait", 4, 80);
    step();
    checkEq("t6_beats", 64'(beat_cnt), 64'd4);
    checkEq("t6_timeout_flag", 64'(timeout_flag), 64'd1);
    checkEq("t6_busy", 64'(busy), 64'd0);
    checkEq("t6_valid", 64'(tvalid), 64'd0);
`else
    repeat (40) step();
    checkEq("t6_beats", 64'(beat_cnt), 64'd1);
    checkEq("t6_valid", 64'(tvalid), 64'd0);
    checkEq("t6_busy", 64'(busy), 64'd1);
    checkEq("t6_timeout_flag", 64'(timeout_flag), 64'd0);
`endif
    tready = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    checkEq("t6_final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_intf_m_axis.md
# rx_intf_m_axis

AXI4-Stream master that carries received baseband/packet words from the receive accelerator up to the PS DMA (S2MM). Words arrive on a simple write-strobe port, are buffered in a single-clock first-word-fall-through FIFO, and are sent as one DMA burst of a programmed length, terminated with TLAST, each time software or the receive controller issues a start pulse. It is the receive-direction counterpart of the tx-side AXIS slave that feeds DMA data into the transmit queues.

## Interface
Parameters:
- MAX_NUM_DMA_SYMBOL, 8192: FIFO depth in words; burst length upper bound.
- MAX_BIT_NUM_DMA_SYMBOL, 14: width of length and count fields.
- C_M_AXIS_TDATA_WIDTH, 64: stream data width.
- TIMEOUT_CYCLES, 1024: stall limit; used only when RX_INTF_M_AXIS_TIMEOUT_EN is defined.

Ports:
- M_AXIS_ACLK  in  1  single clock for the whole block.
- M_AXIS_ARESETN  in  1  reset, asynchronous and active-low.
- DATA_FROM_ACC  in  C_M_AXIS_TDATA_WIDTH  word from the receive accelerator.
- DATA_FROM_ACC_VALID  in  1  write strobe, one word per high cycle.
- fifo_full  out  1  FIFO holds MAX_NUM_DMA_SYMBOL words.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.
- data_count  out  MAX_BIT_NUM_DMA_SYMBOL  words currently in the FIFO.
- M_AXIS_NUM_DMA_SYMBOL  in  MAX_BIT_NUM_DMA_SYMBOL  burst length minus one.
- start_1trans  in  1  one-cycle pulse that launches a burst.
- m_axis_busy  out  1  high while a burst is in progress.
- timeout_flag  out  1  sticky; the burst ended by timeout flush.
- M_AXIS_TVALID  out  1; M_AXIS_TREADY  in  1; M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH; M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8; M_AXIS_TLAST  out  1.

## Operation
- States: IDLE, SEND, FLUSH. FLUSH exists only with the macro.
- IDLE: on start_1trans, latch len = M_AXIS_NUM_DMA_SYMBOL, clear beat counter and timeout_flag, go to SEND. start_1trans is ignored outside IDLE.
- SEND:
  - TVALID = !fifo_empty; TDATA = FIFO head.
  - A handshake (TVALID & TREADY) pops the FIFO and increments the beat counter.
  - TLAST = TVALID & (beat == len).
  - A handshake with TLAST returns to IDLE.
- A burst is len+1 beats. Changes to M_AXIS_NUM_DMA_SYMBOL mid-burst are ignored.
- TSTRB is all ones whenever TVALID is high.
- FIFO write: accepted when DATA_FROM_ACC_VALID & !fifo_full. FULL is sampled before the cycle, so a write on a full FIFO is dropped even if a pop happens in the same cycle; the drop sets overflow.
- Simultaneous push and pop on a non-full, non-empty FIFO: data_count is unchanged.
- The FIFO never underflows, because it pops only on a handshake.
- Writes continue in every state; data not consumed by a burst remains for the next burst.
- data_count and the beat counter are MAX_BIT_NUM_DMA_SYMBOL wide. data_count saturates at MAX_NUM_DMA_SYMBOL; the beat counter never exceeds len.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state IDLE; TVALID, TLAST, m_axis_busy, overflow and timeout_flag are 0; TDATA is 0.
  - FIFO is emptied, so data_count = 0 and fifo_full = 0.
  - A reset mid-burst drops TVALID immediately and discards the partial burst.
- start_1trans high in cycle N: SEND and m_axis_busy are high from N+1. TVALID can be high in N+1 if the FIFO is non-empty.
- Write-to-visibility: a word written in cycle N is FIFO head and can be TVALID in N+1 (FWFT). data_count updates at N+1.
- Once TVALID is asserted, TDATA and TLAST hold until the handshake (AXIS rule).
- m_axis_busy falls in the cycle after the TLAST handshake. The earliest next start is accepted in that same cycle.

## Configuration
- RX_INTF_M_AXIS_TIMEOUT_EN defined:
  - In SEND, a counter counts consecutive cycles with the FIFO empty.
  - At TIMEOUT_CYCLES, go to FLUSH and set timeout_flag.
  - FLUSH drives TVALID=1 and TDATA=0, without popping, until the TLAST handshake, then returns to IDLE.
  - The counter clears on any non-empty cycle.
- Macro undefined: SEND waits indefinitely for data, FLUSH is absent and timeout_flag is tied to 0. The port list is identical in both builds.

## Structure
- Package rx_intf_m_axis_pkg:
  - state enum (IDLE, SEND, FLUSH);
  - TSTRB_ALL constant;
  - default TIMEOUT_CYCLES.
- One sub-module, rx_intf_fifo64_fwft:
  - synchronous FWFT FIFO, depth MAX_NUM_DMA_SYMBOL;
  - ports CLK, RST, DI, WREN, RDEN, DATAO, EMPTY, FULL, data_count.

## Test plan
- Write 4 words 0x11..0x44, len=3, start, TREADY=1 -> 4 beats on consecutive cycles, TLAST on 0x44, busy drops the next cycle, data_count=0.
- len=7 with 8 words, TREADY toggled 1/0 each cycle -> TDATA and TLAST stable while stalled, 8 beats total, TLAST only on beat 8.
- Fill FIFO to 8192 then write once more -> fifo_full=1, overflow=1, data_count=8192, dropped word never appears on the stream.
- Start during an active burst, and change len mid-burst from 3 to 9 -> second start ignored, burst still 4 beats.
- Assert reset after beat 2 of a 4-beat burst -> TVALID=0 immediately, data_count=0, next start with 1 word and len=0 sends that single word with TLAST.
- Macro on, TIMEOUT_CYCLES=16, len=3, only 1 word written -> 1 data beat, then after 16 empty cycles 3 zero beats with TLAST on the last, timeout_flag=1; macro off -> TVALID stays low and busy remains 1.
